pipeline_hazard_ctrl: RTL and testbench

- Hazard and redirect sequencer for the 5-stage (IF/ID/EXE/MEM/WB) CPU pipeline.
- Detects RAW hazards between the instruction in ID and older writers in EXE, MEM and WB, which have no forwarding path. On a hazard it stalls PC and IF/ID and inserts a bubble into ID/EXE.
- Detects taken branch or jump in MEM, flushes the three younger instructions, and sequences the instruction-SRAM refill bubble.
- Sits beside the CPU top and drives the per-stage hold/flush qualifiers of the pipeline registers.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_hazard_cmp.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect sequencer:
// FSM state encoding and register-address constants.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_REFILL = 2'd2,
        ST_ERR    = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Per-stage RAW comparator: flags when an older writer targets a register
// that the instruction in ID reads. Writes to $0 never create a dependency.
module hazard_cmp
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic              reg_write,
    input  logic [REG_AW-1:0] waddr,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    output logic              match
);

    assign match = reg_write && (waddr != ZERO_REG) &&
                   ((waddr == id_rs) || (id_uses_rt && (waddr == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard stall and branch/jump redirect sequencer for the 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to build the stall/flush counters and err_stall flag.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REFILL_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic              mem_branch_taken,
    input  logic              mem_jump,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              id_ex_bubble,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [1:0]        ctrl_state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] REFILL_INIT = 2'(REFILL_CYCLES);

    logic ex_match, mem_match, wb_match;
    logic hazard, redirect;

    ctrl_state_e state_q, state_d;
    logic [1:0]  refill_q, refill_d;

    hazard_cmp u_ex_cmp (
        .reg_write (ex_reg_write),  .waddr (ex_waddr),
        .id_rs     (id_rs),         .id_rt (id_rt),
        .id_uses_rt(id_uses_rt),    .match (ex_match)
    );

    hazard_cmp u_mem_cmp (
        .reg_write (mem_reg_write), .waddr (mem_waddr),
        .id_rs     (id_rs),         .id_rt (id_rt),
        .id_uses_rt(id_uses_rt),    .match (mem_match)
    );

    hazard_cmp u_wb_cmp (
        .reg_write (wb_reg_write),  .waddr (wb_waddr),
        .id_rs     (id_rs),         .id_rt (id_rt),
        .id_uses_rt(id_uses_rt),    .match (wb_match)
    );

    assign hazard   = ex_match | mem_match | wb_match;
    assign redirect = mem_branch_taken | mem_jump;

    // Outputs are gated by reset too, so they read 0 while arst_n is low
    // even if the ID/EXE/MEM/WB inputs still show a dependency.
    always_comb begin
        state_d      = state_q;
        refill_d     = refill_q;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (enable && arst_n) begin
            case (state_q)
                ST_REFILL: begin
                    flush_if_id = 1'b1;
                    if (redirect) begin
                        flush_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        refill_d     = REFILL_INIT;
                    end else if (refill_q <= 2'd1) begin
                        state_d  = ST_RUN;
                        refill_d = '0;
                    end else begin
                        refill_d = refill_q - 2'd1;
                    end
                end
                default: begin
                    if (redirect) begin
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        state_d      = ST_REFILL;
                        refill_d     = REFILL_INIT;
                    end else if (hazard) begin
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = ST_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ST_RUN;
            refill_q <= '0;
        end else begin
            state_q  <= state_d;
            refill_q <= refill_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [2:0]       stall_run_q, stall_run_d;
    logic             err_stall_q, err_stall_d;

    // stall_run counts consecutive bubble cycles; the fourth one latches err_stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_run_d = stall_run_q;
        err_stall_d = err_stall_q;
        if (enable) begin
            if (id_ex_bubble && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_ex_mem && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
            if (id_ex_bubble) begin
                if (stall_run_q < 3'd4) begin
                    stall_run_d = stall_run_q + 3'd1;
                end
                if (stall_run_q >= 3'd3) begin
                    err_stall_d = 1'b1;
                end
            end else begin
                stall_run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            stall_run_q <= '0;
            err_stall_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            stall_run_q <= stall_run_d;
            err_stall_q <= err_stall_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign ctrl_state = err_stall_q ? ST_ERR : state_q;
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign ctrl_state = state_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected
// outputs, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       arst_n;
        logic       enable;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       ex_w;
        logic [4:0] ex_a;
        logic       mem_w;
        logic [4:0] mem_a;
        logic       wb_w;
        logic [4:0] wb_a;
        logic       br;
        logic       jmp;
    } stim_t;

    typedef struct packed {
        logic        ph;
        logic        ih;
        logic        bub;
        logic        fif;
        logic        fie;
        logic        fem;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
    } sb_item_t;

    logic        clk;
    logic        arst_n;
    logic        enable;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rt;
    logic        ex_reg_write, mem_reg_write, wb_reg_write;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
    logic        mem_branch_taken, mem_jump;
    logic        pc_hold, if_id_hold, id_ex_bubble;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt, flush_cnt;

    sb_item_t sb_q[$];
    int       checks = 0;
    int       errors = 0;

    pipeline_hazard_ctrl #(.REFILL_CYCLES(1), .CNT_W(16)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .enable          (enable),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_reg_write    (ex_reg_write),
        .ex_waddr        (ex_waddr),
        .mem_reg_write   (mem_reg_write),
        .mem_waddr       (mem_waddr),
        .wb_reg_write    (wb_reg_write),
        .wb_waddr        (wb_waddr),
        .mem_branch_taken(mem_branch_taken),
        .mem_jump        (mem_jump),
        .pc_hold         (pc_hold),
        .if_id_hold      (if_id_hold),
        .id_ex_bubble    (id_ex_bubble),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .flush_ex_mem    (flush_ex_mem),
        .ctrl_state      (ctrl_state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter values only exist in the feature build; otherwise they read 0.
    function automatic logic [15:0] ec(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return 16'(v);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [1:0] es(input int with_err, input int plain);
`ifdef HAZARD_PERF_CNT_EN
        return 2'(with_err);
`else
        return 2'(plain);
`endif
    endfunction

    function automatic stim_t ms(input logic rst, input logic en,
                                 input int rs, input int rt, input logic urt,
                                 input logic exw, input int exa,
                                 input logic mw, input int ma,
                                 input logic ww, input int wa,
                                 input logic br, input logic jmp);
        stim_t s;
        s.arst_n = rst;  s.enable = en;
        s.id_rs = 5'(rs); s.id_rt = 5'(rt); s.id_uses_rt = urt;
        s.ex_w = exw;    s.ex_a = 5'(exa);
        s.mem_w = mw;    s.mem_a = 5'(ma);
        s.wb_w = ww;     s.wb_a = 5'(wa);
        s.br = br;       s.jmp = jmp;
        return s;
    endfunction

    function automatic exp_t me(input logic ph, input logic ih, input logic bub,
                                input logic fif, input logic fie, input logic fem,
                                input logic [1:0] st, input logic [15:0] sc,
                                input logic [15:0] fc);
        exp_t e;
        e.ph = ph;  e.ih = ih;  e.bub = bub;
        e.fif = fif; e.fie = fie; e.fem = fem;
        e.st = st;  e.sc = sc;  e.fc = fc;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        arst_n           = s.arst_n;
        enable           = s.enable;
        id_rs            = s.id_rs;
        id_rt            = s.id_rt;
        id_uses_rt       = s.id_uses_rt;
        ex_reg_write     = s.ex_w;
        ex_waddr         = s.ex_a;
        mem_reg_write    = s.mem_w;
        mem_waddr        = s.mem_a;
        wb_reg_write     = s.wb_w;
        wb_waddr         = s.wb_a;
        mem_branch_taken = s.br;
        mem_jump         = s.jmp;
    endtask

    // Inputs change 1 time unit after the rising edge; the monitor samples at
    // the falling edge, before the next rising edge can update any state.
    task automatic applyStimulus(input string name, input stim_t s, input exp_t e);
        sb_item_t it;
        @(posedge clk);
        #1;
        drive(s);
        it.name = name;
        it.e    = e;
        sb_q.push_back(it);
    endtask

    task automatic checkOutput(input sb_item_t it);
        exp_t got;
        got = me(pc_hold, if_id_hold, id_ex_bubble, flush_if_id, flush_id_ex,
                 flush_ex_mem, ctrl_state, stall_cnt, flush_cnt);
        checks++;
        if (got !== it.e) begin
            errors++;
            $display("[TB] FAIL %s got ph=%b ih=%b bub=%b fif=%b fie=%b fem=%b st=%0d sc=%0d fc=%0d want ph=%b ih=%b bub=%b fif=%b fie=%b fem=%b st=%0d sc=%0d fc=%0d",
                     it.name, got.ph, got.ih, got.bub, got.fif, got.fie, got.fem,
                     got.st, got.sc, got.fc, it.e.ph, it.e.ih, it.e.bub, it.e.fif,
                     it.e.fie, it.e.fem, it.e.st, it.e.sc, it.e.fc);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            checkOutput(sb_q.pop_front());
        end
    end

    initial begin
        drive(ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        applyStimulus("reset",        ms(0,1, 0,0,0, 0,0, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd0, ec(0), ec(0)));
        applyStimulus("idle",         ms(1,1, 0,0,0, 0,0, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd0, ec(0), ec(0)));
        applyStimulus("lu_ex",        ms(1,1, 8,0,0, 1,8, 0,0, 0,0, 0,0), me(1,1,1,0,0,0, 2'd0, ec(0), ec(0)));
        applyStimulus("lu_mem",       ms(1,1, 8,0,0, 0,0, 1,8, 0,0, 0,0), me(1,1,1,0,0,0, 2'd1, ec(1), ec(0)));
        applyStimulus("lu_wb",        ms(1,1, 8,0,0, 0,0, 0,0, 1,8, 0,0), me(1,1,1,0,0,0, 2'd1, ec(2), ec(0)));
        applyStimulus("lu_done",      ms(1,1, 8,0,0, 0,0, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd1, ec(3), ec(0)));
        applyStimulus("zero_reg",     ms(1,1, 0,0,0, 1,0, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd0, ec(3), ec(0)));
        applyStimulus("rt_unused",    ms(1,1, 1,9,0, 1,9, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd0, ec(3), ec(0)));
        applyStimulus("rt_used",      ms(1,1, 1,9,1, 1,9, 0,0, 0,0, 0,0), me(1,1,1,0,0,0, 2'd0, ec(3), ec(0)));
        applyStimulus("br_in_stall",  ms(1,1, 1,9,1, 1,9, 0,0, 0,0, 1,0), me(0,0,0,1,1,1, 2'd1, ec(4), ec(0)));
        applyStimulus("refill",       ms(1,1, 1,9,1, 1,9, 0,0, 0,0, 0,0), me(0,0,0,1,0,0, 2'd2, ec(4), ec(1)));
        applyStimulus("after_refill", ms(1,1, 0,0,0, 0,0, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd0, ec(4), ec(1)));
        applyStimulus("jump",         ms(1,1, 0,0,0, 0,0, 0,0, 0,0, 0,1), me(0,0,0,1,1,1, 2'd0, ec(4), ec(1)));
        applyStimulus("refill_frz1",  ms(1,0, 0,0,0, 0,0, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd2, ec(4), ec(2)));
        applyStimulus("refill_frz2",  ms(1,0, 0,0,0, 0,0, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd2, ec(4), ec(2)));
        applyStimulus("refill_resume",ms(1,1, 0,0,0, 0,0, 0,0, 0,0, 0,0), me(0,0,0,1,0,0, 2'd2, ec(4), ec(2)));
        applyStimulus("run_again",    ms(1,1, 0,0,0, 0,0, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd0, ec(4), ec(2)));
        applyStimulus("hz_disabled",  ms(1,0, 5,0,0, 1,5, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd0, ec(4), ec(2)));
        applyStimulus("hz_enabled",   ms(1,1, 5,0,0, 1,5, 0,0, 0,0, 0,0), me(1,1,1,0,0,0, 2'd0, ec(4), ec(2)));
        applyStimulus("hz_stall2",    ms(1,1, 5,0,0, 1,5, 0,0, 0,0, 0,0), me(1,1,1,0,0,0, 2'd1, ec(5), ec(2)));
        applyStimulus("async_reset",  ms(0,1, 5,0,0, 1,5, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, 2'd0, ec(0), ec(0)));
        applyStimulus("long_st1",     ms(1,1, 5,0,0, 1,5, 0,0, 0,0, 0,0), me(1,1,1,0,0,0, 2'd0, ec(0), ec(0)));
        applyStimulus("long_st2",     ms(1,1, 5,0,0, 1,5, 0,0, 0,0, 0,0), me(1,1,1,0,0,0, 2'd1, ec(1), ec(0)));
        applyStimulus("long_st3",     ms(1,1, 5,0,0, 0,0, 1,5, 0,0, 0,0), me(1,1,1,0,0,0, 2'd1, ec(2), ec(0)));
        applyStimulus("long_st4",     ms(1,1, 5,0,0, 0,0, 0,0, 1,5, 0,0), me(1,1,1,0,0,0, 2'd1, ec(3), ec(0)));
        applyStimulus("err_flag",     ms(1,1, 5,0,0, 0,0, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, es(3,1), ec(4), ec(0)));
        applyStimulus("err_sticky",   ms(1,1, 0,0,0, 0,0, 0,0, 0,0, 0,0), me(0,0,0,0,0,0, es(3,0), ec(4), ec(0)));

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain got pending=%0d want pending=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
